// File: rtl/burst_arb.sv
// Two-source round-robin burst arbiter feeding the weighting datapath input port.
// A frame is NUM_BURSTS bursts of BURST_LEN samples, then a wait for the datapath's out_done.
module burst_arb #(
    parameter int BURST_LEN  = 12,
    parameter int GAP_LEN    = 3,
    parameter int NUM_BURSTS = 10,
    parameter int DW         = 12,
    parameter int WW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] s0_data_i,
    input  logic [DW-1:0] s0_data_q,
    input  logic [WW-1:0] s0_w_i,
    input  logic [WW-1:0] s0_w_q,
    input  logic [DW-1:0] s1_data_i,
    input  logic [DW-1:0] s1_data_q,
    input  logic [WW-1:0] s1_w_i,
    input  logic [WW-1:0] s1_w_q,
    output logic          rd0,
    output logic          rd1,
    input  logic          out_done,
    output logic [DW-1:0] in_data_i,
    output logic [DW-1:0] in_data_q,
    output logic [WW-1:0] in_w_i,
    output logic [WW-1:0] in_w_q,
    output logic          in_en,
    output logic          gnt_id,
    output logic [3:0]    burst_cnt,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, ARB, SEND, GAP, DRAIN, DONE} state_t;

    state_t        state_q;
    logic          ptr_q, gnt_q, done_seen_q, in_en_q, busy_q, done_q;
    logic [3:0]    smp_cnt_q, gap_cnt_q, burst_cnt_q, burst_cnt_d;
    logic [DW-1:0] data_i_q, data_q_q;
    logic [WW-1:0] w_i_q, w_q_q;
    logic          arb_win;

    // Lone requester wins outright; on contention the pointer decides.
    assign arb_win     = (req0 && req1) ? ptr_q : req1;
    assign burst_cnt_d = burst_cnt_q + 4'd1;

    assign rd0 = (state_q == SEND) && !gnt_q;
    assign rd1 = (state_q == SEND) &&  gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            done_seen_q <= 1'b0;
            in_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            smp_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            burst_cnt_q <= '0;
            data_i_q    <= '0;
            data_q_q    <= '0;
            w_i_q       <= '0;
            w_q_q       <= '0;
        end else begin
            in_en_q <= 1'b0;
            done_q  <= 1'b0;
            // Latch out_done early so a pulse arriving mid-frame is not lost.
            if (state_q != IDLE && out_done)
                done_seen_q <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= ARB;
                    busy_q      <= 1'b1;
                    burst_cnt_q <= '0;
                    done_seen_q <= 1'b0;
                end
                ARB: if (req0 || req1) begin
                    gnt_q     <= arb_win;
                    ptr_q     <= ~arb_win;
                    smp_cnt_q <= '0;
                    state_q   <= SEND;
                end
                SEND: begin
                    in_en_q   <= 1'b1;
                    data_i_q  <= gnt_q ? s1_data_i : s0_data_i;
                    data_q_q  <= gnt_q ? s1_data_q : s0_data_q;
                    w_i_q     <= gnt_q ? s1_w_i    : s0_w_i;
                    w_q_q     <= gnt_q ? s1_w_q    : s0_w_q;
                    smp_cnt_q <= smp_cnt_q + 4'd1;
                    if (smp_cnt_q == 4'(BURST_LEN - 1)) begin
                        burst_cnt_q <= burst_cnt_d;
                        gap_cnt_q   <= '0;
                        if (burst_cnt_d == 4'(NUM_BURSTS))
                            state_q <= DRAIN;
                        else if (GAP_LEN == 0)
                            state_q <= ARB;
                        else
                            state_q <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q + 4'd1;
                    if (gap_cnt_q == 4'(GAP_LEN - 1))
                        state_q <= ARB;
                end
                DRAIN: if (out_done || done_seen_q) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_data_i = data_i_q;
    assign in_data_q = data_q_q;
    assign in_w_i    = w_i_q;
    assign in_w_q    = w_q_q;
    assign in_en     = in_en_q;
    assign gnt_id    = gnt_q;
    assign burst_cnt = burst_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_burst_arb.sv
// Bench for burst_arb: frame scenarios from a table with a sample scoreboard,
// plus hand sequences for async reset and a minimal-parameter instance.
module tb_burst_arb;

    logic        clk, rst, start, req0, req1, out_done;
    logic [11:0] s0_data_i, s0_data_q, s1_data_i, s1_data_q;
    logic [3:0]  s0_w_i, s0_w_q, s1_w_i, s1_w_q;
    logic        rd0, rd1, in_en, gnt_id, busy, done;
    logic [11:0] in_data_i, in_data_q;
    logic [3:0]  in_w_i, in_w_q, burst_cnt;

    logic        sm_start, sm_req0, sm_req1, sm_out_done;
    logic        sm_rd0, sm_rd1, sm_in_en, sm_gnt_id, sm_busy, sm_done;
    logic [11:0] sm_in_data_i, sm_in_data_q;
    logic [3:0]  sm_in_w_i, sm_in_w_q, sm_burst_cnt;

    burst_arb u_dut (
        .clk(clk), .rst(rst), .start(start), .req0(req0), .req1(req1),
        .s0_data_i(s0_data_i), .s0_data_q(s0_data_q), .s0_w_i(s0_w_i), .s0_w_q(s0_w_q),
        .s1_data_i(s1_data_i), .s1_data_q(s1_data_q), .s1_w_i(s1_w_i), .s1_w_q(s1_w_q),
        .rd0(rd0), .rd1(rd1), .out_done(out_done),
        .in_data_i(in_data_i), .in_data_q(in_data_q), .in_w_i(in_w_i), .in_w_q(in_w_q),
        .in_en(in_en), .gnt_id(gnt_id), .burst_cnt(burst_cnt), .busy(busy), .done(done)
    );

    burst_arb #(.BURST_LEN(1), .GAP_LEN(0), .NUM_BURSTS(1)) u_small (
        .clk(clk), .rst(rst), .start(sm_start), .req0(sm_req0), .req1(sm_req1),
        .s0_data_i(12'hABC), .s0_data_q(12'h123), .s0_w_i(4'h7), .s0_w_q(4'h2),
        .s1_data_i(12'h0F0), .s1_data_q(12'h0E0), .s1_w_i(4'h1), .s1_w_q(4'h3),
        .rd0(sm_rd0), .rd1(sm_rd1), .out_done(sm_out_done),
        .in_data_i(sm_in_data_i), .in_data_q(sm_in_data_q), .in_w_i(sm_in_w_i), .in_w_q(sm_in_w_q),
        .in_en(sm_in_en), .gnt_id(sm_gnt_id), .burst_cnt(sm_burst_cnt), .busy(sm_busy), .done(sm_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- sources + scoreboard monitor ----------------
    logic [11:0] idx0 = 12'd0, idx1 = 12'd0;
    logic [31:0] sbq[$];
    int          gnt_log[$], run_log[$], gap_log[$], bc_log[$];
    int          run = 0, low = 0;
    logic        prev_en = 1'b0, seen_fall = 1'b0;

    function automatic void set_src();
        s0_data_i = 12'h100 + idx0;
        s0_data_q = 12'h300 + idx0;
        s0_w_i    = idx0[3:0];
        s0_w_q    = 4'hF - idx0[3:0];
        s1_data_i = 12'h800 + idx1;
        s1_data_q = 12'hA00 + idx1;
        s1_w_i    = idx1[3:0] ^ 4'h5;
        s1_w_q    = 4'h9;
    endfunction

    function automatic void clear_logs();
        gnt_log.delete(); run_log.delete(); gap_log.delete(); bc_log.delete();
        run = 0; low = 0; seen_fall = 1'b0;
    endfunction

    initial begin
        logic adv0, adv1;
        logic [31:0] exp;
        set_src();
        forever begin
            @(negedge clk);
            adv0 = 1'b0;
            adv1 = 1'b0;
            if (rst) begin
                sbq.delete();
                prev_en = 1'b0;
                run = 0;
                low = 0;
            end else begin
                if (in_en) begin
                    if (sbq.size() == 0) chk("sb_unexpected_en", 32'd1, 32'd0);
                    else begin
                        exp = sbq.pop_front();
                        chk("sb_sample", {in_data_i, in_data_q, in_w_i, in_w_q}, exp);
                    end
                    if (!prev_en) begin
                        gnt_log.push_back(int'(gnt_id));
                        if (seen_fall) gap_log.push_back(low);
                    end
                    run++;
                end else begin
                    if (prev_en) begin
                        run_log.push_back(run);
                        bc_log.push_back(int'(burst_cnt));
                        seen_fall = 1'b1;
                        run = 0;
                        low = 0;
                    end
                    low++;
                end
                prev_en = in_en;
                if (rd0) begin sbq.push_back({s0_data_i, s0_data_q, s0_w_i, s0_w_q}); adv0 = 1'b1; end
                if (rd1) begin sbq.push_back({s1_data_i, s1_data_q, s1_w_i, s1_w_q}); adv1 = 1'b1; end
            end
            @(posedge clk);
            #1;
            if (adv0) idx0 = idx0 + 12'd1;
            if (adv1) idx1 = idx1 + 12'd1;
            set_src();
        end
    end

    // ---------------- scenario table ----------------
    typedef struct {
        logic       r0;
        logic       r1;
        logic [9:0] gnt;   // bit k = expected channel of burst k
        int         mode;  // 0 plain, 1 req0 raised/dropped mid-burst, 2 early out_done
    } frame_t;

    frame_t tbl[4];

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; out_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
        sm_start = 1'b0; sm_out_done = 1'b0; sm_req0 = 1'b0; sm_req1 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_frame(input frame_t f, input bit no_reset, input string tag);
        int   cyc;
        logic od_sent;
        if (!no_reset) do_reset();
        clear_logs();
        req0 = f.r0;
        req1 = f.r1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        od_sent = 1'b0;
        while (!(burst_cnt == 4'd10 && !in_en) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (f.mode == 1) begin
                if (gnt_log.size() == 3 && run == 5) req0 = 1'b1;
                if (gnt_log.size() == 4 && run == 3) req0 = 1'b0;
            end
            out_done = 1'b0;
            if (f.mode == 2 && gnt_log.size() == 8 && run == 6 && !od_sent) begin
                out_done = 1'b1;
                od_sent = 1'b1;
            end
        end
        out_done = 1'b0;
        chk({tag, "_frame_timeout"}, 32'(cyc >= 1000), 32'd0);
        if (f.mode == 2) begin
            chk({tag, "_done_early_seen"}, done, 1'b1);
            @(posedge clk); #1;
        end else begin
            chk({tag, "_drain_no_done"}, done, 1'b0);
            chk({tag, "_drain_busy"}, busy, 1'b1);
            repeat (3) begin @(posedge clk); #1; end
            chk({tag, "_drain_wait"}, {done, busy}, 2'b01);
            out_done = 1'b1;
            @(posedge clk); #1;
            out_done = 1'b0;
            chk({tag, "_done_pulse"}, done, 1'b1);
            @(posedge clk); #1;
        end
        chk({tag, "_done_1cyc"}, done, 1'b0);
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_burst_cnt_hold"}, burst_cnt, 4'd10);
        chk({tag, "_sb_empty"}, sbq.size(), 32'd0);
        chk({tag, "_n_bursts"}, gnt_log.size(), 32'd10);
        chk({tag, "_n_gaps"}, gap_log.size(), 32'd9);
        for (int k = 0; k < 10 && k < gnt_log.size(); k++) begin
            chk({tag, "_gnt"}, gnt_log[k], 32'(f.gnt[k]));
            chk({tag, "_run_len"}, run_log[k], 32'd12);
            chk({tag, "_burst_cnt"}, bc_log[k], 32'(k + 1));
        end
        foreach (gap_log[k]) chk({tag, "_gap_len"}, gap_log[k], 32'd4);
    endtask

    // ---------------- main ----------------
    initial begin
        int cyc, en_hi, rd_hi;
        logic [31:0] cap;

        tbl[0] = '{1'b1, 1'b0, 10'b0000000000, 0};
        tbl[1] = '{1'b1, 1'b1, 10'b1010101010, 0};
        tbl[2] = '{1'b0, 1'b1, 10'b1111110111, 1};
        tbl[3] = '{1'b1, 1'b0, 10'b0000000000, 2};

        rst = 1'b1; start = 1'b0; out_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
        sm_start = 1'b0; sm_out_done = 1'b0; sm_req0 = 1'b0; sm_req1 = 1'b0;
        #3;
        chk("rst_outs", {in_en, rd0, rd1, gnt_id, busy, done, burst_cnt}, 10'd0);
        chk("rst_data", {in_data_i, in_data_q, in_w_i, in_w_q}, 32'd0);

        for (int i = 0; i < 4; i++)
            run_frame(tbl[i], 1'b0, $sformatf("row%0d", i));

        // Async reset mid-burst 2, then a fresh frame must start on ch0.
        do_reset();
        clear_logs();
        req0 = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(gnt_log.size() == 2 && run == 4) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("arst_reach_timeout", 32'(cyc >= 1000), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_immediate", {in_en, rd0, rd1, busy, burst_cnt}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(tbl[1], 1'b1, "arst_fresh");

        // Minimal instance: one single-sample burst, start held in DRAIN.
        do_reset();
        sm_req0 = 1'b1;
        sm_start = 1'b1;
        @(posedge clk); #1;
        sm_start = 1'b0;
        en_hi = 0;
        rd_hi = 0;
        cap = '0;
        repeat (7) begin
            if (sm_rd0) rd_hi++;
            @(posedge clk); #1;
            if (sm_in_en) begin
                en_hi++;
                cap = {sm_in_data_i, sm_in_data_q, sm_in_w_i, sm_in_w_q};
            end
            if (en_hi != 0) sm_start = 1'b1;
        end
        chk("sm_en_cycles", en_hi, 32'd1);
        chk("sm_rd_cycles", rd_hi, 32'd1);
        chk("sm_data", cap, {12'hABC, 12'h123, 4'h7, 4'h2});
        chk("sm_drain_state", {sm_burst_cnt, sm_busy, sm_done, sm_in_en, sm_gnt_id}, {4'd1, 4'b1000});
        sm_out_done = 1'b1;
        @(posedge clk); #1;
        sm_out_done = 1'b0;
        sm_start = 1'b0;
        chk("sm_done", {sm_done, sm_busy}, 2'b11);
        @(posedge clk); #1;
        chk("sm_after_done", {sm_done, sm_busy, sm_burst_cnt}, {2'b00, 4'd1});
        @(posedge clk); #1;
        chk("sm_idle", {sm_busy, sm_in_en}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/burst_arb.md
Name: burst_arb

Overview:
- Shares the single I/Q-plus-weight input port of the weighting datapath between two sample sources (ch0, ch1).
- Sequences a frame of NUM_BURSTS bursts. Each burst is BURST_LEN consecutive samples, and consecutive bursts are separated by at least GAP_LEN+1 idle cycles.
- Sources are granted round-robin. After the last burst, the block waits for the datapath's out_done and pulses done.
- It sits between the stimulus/sample sources and the datapath input (in_data_*, in_w_*, in_en).

Parameters:
BURST_LEN, 12, samples per burst (1..15)
GAP_LEN, 3, idle cycles in GAP state between bursts (0..15)
NUM_BURSTS, 10, bursts per frame (1..15)
DW, 12, I/Q sample width
WW, 4, weight width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  frame start request, sampled in IDLE only
req0  in  1  ch0 has a burst ready
req1  in  1  ch1 has a burst ready
s0_data_i  in  DW  ch0 I sample, valid while rd0=1
s0_data_q  in  DW  ch0 Q sample
s0_w_i  in  WW  ch0 I weight
s0_w_q  in  WW  ch0 Q weight
s1_data_i, s1_data_q, s1_w_i, s1_w_q  in  DW/DW/WW/WW  ch1 equivalents
rd0  out  1  pull strobe to ch0: one sample consumed per cycle high
rd1  out  1  pull strobe to ch1
out_done  in  1  datapath finished processing frame (level or pulse)
in_data_i  out  DW  to datapath
in_data_q  out  DW  to datapath
in_w_i  out  WW  to datapath
in_w_q  out  WW  to datapath
in_en  out  1  datapath input valid
gnt_id  out  1  channel owning current/last burst
burst_cnt  out  4  bursts completed in current frame
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer favours ch0; sample counter, gap counter and done_seen flag cleared. Reset is asynchronous: asserting it mid-burst clears everything immediately, with no partial-burst completion.
- All outputs except rd0/rd1 are registered. rd0/rd1 decode combinationally from state and gnt_id.
- States: IDLE, ARB, SEND, GAP, DRAIN, DONE.
- IDLE:
  - start=1 -> ARB; burst_cnt<=0; done_seen<=0.
  - start in any other state is ignored.
- ARB:
  - No req -> stay in ARB.
  - One req -> grant that channel.
  - Both req -> grant the pointer's channel.
  - On grant: gnt_id<=winner; pointer<=other channel; sample counter<=0; -> SEND.
- SEND:
  - rd[gnt_id]=1 every cycle; the other rd is 0.
  - Each cycle the granted source's four fields are registered into in_data_*/in_w_* with in_en<=1. Latency rd->in_en is 1 cycle.
  - After the BURST_LEN-th rd cycle: burst_cnt+1; if the new count == NUM_BURSTS -> DRAIN, else -> GAP (or ARB if GAP_LEN=0).
  - req deasserting mid-burst is ignored; the burst always runs full length.
- GAP: in_en<=0; hold for GAP_LEN cycles -> ARB. The minimum number of in_en-low cycles between bursts is GAP_LEN+1.
- in_en=0 outside the registered SEND cycles. in_data_*/in_w_* hold their last value while in_en=0.
- done_seen is set by out_done=1 in any non-IDLE state, so an early out_done is not lost.
- DRAIN: in_en<=0. When out_done=1 or done_seen=1 -> DONE, with done<=1 registered in the same transition.
- DONE: done<=0; -> IDLE. done is therefore exactly 1 cycle. burst_cnt holds its value until the next start.
- Pointer persists across frames and is reset only by rst.
- busy=1 from the cycle after start is accepted until the cycle after done.

Test Plan:
1. Defaults, req0 held high, req1=0, start pulse → 10 bursts all from ch0; 12 in_en-high cycles each; exactly 4 low cycles between bursts; rd0 leads in_en by 1 cycle; burst_cnt 1..10.
2. req0=req1=1 held, start → grants alternate ch0,ch1,…; gnt_id pattern 0101010101; in_data follows the corresponding source values.
3. Only req1 high, then req0 raised mid-burst 3 → burst 3 completes on ch1; burst 4 goes to ch0 (pointer); req0 drop during its burst does not shorten it (12 samples).
4. out_done pulsed 1 cycle during burst 8, then never again → done pulses 1 cycle immediately after burst 10 enters DRAIN; busy falls next cycle.
5. rst asserted at sample 5 of burst 2 (asynchronously, between edges) → in_en, rd0/rd1, busy and burst_cnt go 0 immediately; a fresh start yields a full 10-burst frame with ch0 first.
6. GAP_LEN=0, NUM_BURSTS=1, BURST_LEN=1 → start, req0 → one in_en cycle; DRAIN; out_done → done; start held high in DRAIN is ignored.
